// File: rtl/axistream_pkt_fifo_pkg.sv
// Shared definitions for the store-and-forward packet FIFO: sizing helpers and FSM states.
// Imported by the top level; the CLOG2 macro is also used by the storage RAM.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package axistream_pkt_fifo_pkg;

   typedef enum logic {
      ST_ACCEPT = 1'b0,
      ST_DROP   = 1'b1
   } state_e;

   localparam int DROP_CNT_W = 16;

   function automatic int keep_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port packet storage, one write and one registered read port, read-first.
// One-cycle read latency; no flow control of its own.
module pkt_fifo_ram #(
   parameter int WIDTH      = 73,
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = `CLOG2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]      wr_dat_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [WIDTH-1:0]      rd_dat_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_dat_q;

   // No reset on the array or read register so the tools map this onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
      if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/axistream_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet becomes visible only once its TLAST is stored,
// first beat out two cycles after commit; never backpressures the input, overflowing packets are dropped whole.
module axistream_pkt_fifo
   import axistream_pkt_fifo_pkg::*;
#(
   parameter int  DATA_WIDTH = 64,
   parameter int  DEPTH      = 512,
   localparam int KEEP_WIDTH = keep_width(DATA_WIDTH),
   localparam int ADDR_WIDTH = `CLOG2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_TDATA,
   input  logic [KEEP_WIDTH-1:0] s_TKEEP,
   input  logic                  s_TLAST,
   input  logic                  s_TVALID,
   output logic                  s_TREADY,
   output logic [DATA_WIDTH-1:0] m_TDATA,
   output logic [KEEP_WIDTH-1:0] m_TKEEP,
   output logic                  m_TLAST,
   output logic                  m_TVALID,
   input  logic                  m_TREADY,
   output logic [ADDR_WIDTH:0]   pkt_count,
   output logic [DROP_CNT_W-1:0] drop_count,
   output logic                  drop_pulse
);

   localparam int PTR_W   = ADDR_WIDTH + 1;
   localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;
   localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W-1:0]      PTR_DEPTH = PTR_W'(DEPTH);
   localparam logic [DROP_CNT_W-1:0] DROP_ONE  = DROP_CNT_W'(1);

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       wr_commit_q, wr_commit_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]       pkt_count_q, pkt_count_d;
   logic [DROP_CNT_W-1:0]  drop_count_q, drop_count_d;
   logic                   drop_pulse_q;
   logic                   tready_q;

   logic [ENTRY_W-1:0]     out_q, out_d;
   logic                   m_vld_q, m_vld_d;
   logic [ENTRY_W-1:0]     sk_q, sk_d;
   logic                   sk_vld_q, sk_vld_d;
   logic                   rd_vld_q;

   logic [PTR_W-1:0]       used;
   logic                   full;
   logic                   s_acc;
   logic                   wr_en;
   logic                   commit;
   logic                   drop;
   logic                   pop;
   logic                   last_pop;
   logic                   readable;
   logic                   rd_en;
   logic [1:0]             occ_after;
   logic [ENTRY_W-1:0]     ram_rdata;

   assign used     = wr_ptr_q - rd_ptr_q;
   assign full     = (used == PTR_DEPTH);
   assign s_acc    = s_TVALID && tready_q;
   assign pop      = m_vld_q && m_TREADY;
   assign last_pop = pop && out_q[ENTRY_W-1];
   assign readable = (rd_ptr_q != wr_commit_q);

   // Write side: a full FIFO rewinds to the last commit point, discarding the whole packet.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      wr_en       = 1'b0;
      commit      = 1'b0;
      drop        = 1'b0;
      case (state_q)
         ST_ACCEPT: begin
            if (s_acc) begin
               if (!full) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (s_TLAST) begin
                     commit      = 1'b1;
                     wr_commit_d = wr_ptr_q + PTR_ONE;
                  end
               end else begin
                  drop     = 1'b1;
                  wr_ptr_d = wr_commit_q;
                  if (!s_TLAST) state_d = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (s_acc && s_TLAST) state_d = ST_ACCEPT;
         end
         default: state_d = ST_ACCEPT;
      endcase
   end

   // In-flight RAM reads count against the two-entry output stage so nothing can overflow it.
   always_comb begin
      occ_after = 2'(m_vld_q) + 2'(sk_vld_q) + 2'(rd_vld_q) - 2'(pop);
      rd_en     = readable && (occ_after < 2'd2);
      rd_ptr_d  = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
   end

   always_comb begin
      out_d    = out_q;
      m_vld_d  = m_vld_q;
      sk_d     = sk_q;
      sk_vld_d = sk_vld_q;
      if (!m_vld_q || pop) begin
         if (sk_vld_q) begin
            out_d    = sk_q;
            m_vld_d  = 1'b1;
            sk_vld_d = rd_vld_q;
            if (rd_vld_q) sk_d = ram_rdata;
         end else if (rd_vld_q) begin
            out_d   = ram_rdata;
            m_vld_d = 1'b1;
         end else begin
            m_vld_d = 1'b0;
         end
      end else if (rd_vld_q) begin
         sk_d     = ram_rdata;
         sk_vld_d = 1'b1;
      end
   end

   always_comb begin
      pkt_count_d = pkt_count_q;
      if (commit && !last_pop)      pkt_count_d = pkt_count_q + PTR_ONE;
      else if (!commit && last_pop) pkt_count_d = pkt_count_q - PTR_ONE;
      drop_count_d = drop_count_q;
      if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_ONE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_ACCEPT;
         wr_ptr_q     <= '0;
         wr_commit_q  <= '0;
         rd_ptr_q     <= '0;
         pkt_count_q  <= '0;
         drop_count_q <= '0;
         drop_pulse_q <= 1'b0;
         tready_q     <= 1'b0;
         out_q        <= '0;
         m_vld_q      <= 1'b0;
         sk_q         <= '0;
         sk_vld_q     <= 1'b0;
         rd_vld_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         wr_commit_q  <= wr_commit_d;
         rd_ptr_q     <= rd_ptr_d;
         pkt_count_q  <= pkt_count_d;
         drop_count_q <= drop_count_d;
         drop_pulse_q <= drop;
         tready_q     <= 1'b1;
         out_q        <= out_d;
         m_vld_q      <= m_vld_d;
         sk_q         <= sk_d;
         sk_vld_q     <= sk_vld_d;
         rd_vld_q     <= rd_en;
      end
   end

   pkt_fifo_ram #(
      .WIDTH      (ENTRY_W),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_dat_i  ({s_TLAST, s_TKEEP, s_TDATA}),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_dat_o  (ram_rdata)
   );

   assign s_TREADY   = tready_q;
   assign m_TVALID   = m_vld_q;
   assign m_TLAST    = out_q[ENTRY_W-1];
   assign m_TKEEP    = out_q[DATA_WIDTH +: KEEP_WIDTH];
   assign m_TDATA    = out_q[DATA_WIDTH-1:0];
   assign pkt_count  = pkt_count_q;
   assign drop_count = drop_count_q;
   assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_axistream_pkt_fifo.sv
// Randomized bench for the packet FIFO: an expected-beat queue stands in for the FIFO contents.
module tb_axistream_pkt_fifo;

   localparam int DW    = 64;
   localparam int KW    = DW / 8;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   typedef struct packed {
      logic          last;
      logic [KW-1:0] keep;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_TDATA = '0;
   logic [KW-1:0] s_TKEEP = '0;
   logic          s_TLAST = 1'b0;
   logic          s_TVALID = 1'b0;
   logic          s_TREADY;
   logic [DW-1:0] m_TDATA;
   logic [KW-1:0] m_TKEEP;
   logic          m_TLAST;
   logic          m_TVALID;
   logic          m_TREADY = 1'b0;
   logic [AW:0]   pkt_count;
   logic [15:0]   drop_count;
   logic          drop_pulse;

   always #5 clk = ~clk;

   axistream_pkt_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_TDATA    (s_TDATA),
      .s_TKEEP    (s_TKEEP),
      .s_TLAST    (s_TLAST),
      .s_TVALID   (s_TVALID),
      .s_TREADY   (s_TREADY),
      .m_TDATA    (m_TDATA),
      .m_TKEEP    (m_TKEEP),
      .m_TLAST    (m_TLAST),
      .m_TVALID   (m_TVALID),
      .m_TREADY   (m_TREADY),
      .pkt_count  (pkt_count),
      .drop_count (drop_count),
      .drop_pulse (drop_pulse)
   );

   int    checks = 0;
   int    errors = 0;
   beat_t exp_q[$];
   int    n_hs = 0;
   int    n_drop = 0;
   bit    rand_rdy = 1'b0;
   bit    stalled = 1'b0;
   logic [$bits(beat_t):0] hold_pay;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: scoreboard on every handshake, payload must hold while stalled.
   always @(negedge clk) begin
      beat_t obs;
      obs = {m_TLAST, m_TKEEP, m_TDATA};
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) check("stall_hold", {m_TVALID, obs}, hold_pay);
         if (drop_pulse) n_drop++;
         if (m_TVALID && m_TREADY) begin
            n_hs++;
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("beat", obs, exp_q.pop_front());
         end
         stalled  = m_TVALID && !m_TREADY;
         hold_pay = {m_TVALID, obs};
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) m_TREADY = ($urandom_range(99) < 60);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input beat_t b);
      s_TVALID = 1'b1;
      {s_TLAST, s_TKEEP, s_TDATA} = b;
      tick();
      s_TVALID = 1'b0;
   endtask

   function automatic beat_t rnd_beat(input bit last);
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.last = last;
      return b;
   endfunction

   task automatic send_pkt(input int len, input bit kept, input int gap_pct);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b = rnd_beat(i == len - 1);
         if (kept) exp_q.push_back(b);
         send_beat(b);
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) tick();
      end
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      check(tag, exp_q.size(), 0);
      repeat (3) tick();
   endtask

   initial begin
      beat_t b;
      beat_t first;
      int    h0;
      int    d0;
      int    len;
      int    n;

      // Reset values
      repeat (3) tick();
      check("rst_tready", s_TREADY, 0);
      check("rst_mvalid", m_TVALID, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_drop_pulse", drop_pulse, 0);
      rst_n = 1'b1;
      tick();
      check("tready_after_rst", s_TREADY, 1);

      // Single 3-beat packet, sink always ready
      m_TREADY = 1'b1;
      first = rnd_beat(1'b0);
      first.keep = 8'hFF;
      exp_q.push_back(first);
      send_beat(first);
      b = rnd_beat(1'b0);
      b.keep = 8'hFF;
      exp_q.push_back(b);
      send_beat(b);
      b = rnd_beat(1'b1);
      b.keep = 8'h0F;
      exp_q.push_back(b);
      send_beat(b);
      check("single_pkt_count", pkt_count, 1);
      tick();
      check("single_lat_t1_vld", m_TVALID, 0);
      tick();
      check("single_lat_t2_vld", m_TVALID, 1);
      check("single_first_data", m_TDATA, first.data);
      wait_drain("single_drain");
      check("single_pkt_count_end", pkt_count, 0);
      check("single_drop_count", drop_count, 0);

      // Atomicity: an unterminated packet is never visible
      m_TREADY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         b = rnd_beat(1'b0);
         exp_q.push_back(b);
         send_beat(b);
      end
      repeat (3) tick();
      check("atom_no_vld", m_TVALID, 0);
      check("atom_pkt_count0", pkt_count, 0);
      b = rnd_beat(1'b1);
      exp_q.push_back(b);
      send_beat(b);
      repeat (4) tick();
      check("atom_vld", m_TVALID, 1);
      h0 = n_hs;
      m_TREADY = 1'b1;
      repeat (6) tick();
      check("atom_b2b", n_hs - h0, 6);
      wait_drain("atom_drain");

      // Overflow: 10 beats fit; two of them move into the prefetch stage, so 9 more overflow
      m_TREADY = 1'b0;
      d0 = n_drop;
      send_pkt(10, 1'b1, 0);
      send_pkt(9, 1'b0, 0);
      repeat (3) tick();
      check("ovf_drop_pulse", n_drop - d0, 1);
      check("ovf_drop_count", drop_count, 1);
      check("ovf_pkt_count", pkt_count, 1);
      m_TREADY = 1'b1;
      wait_drain("ovf_drain");
      check("ovf_pkt_count_end", pkt_count, 0);

      // Exact fit into an empty FIFO, then one beat too many
      send_pkt(DEPTH, 1'b1, 0);
      wait_drain("fit_drain");
      check("fit_no_drop", drop_count, 1);
      send_pkt(DEPTH + 1, 1'b0, 0);
      repeat (3) tick();
      check("fit_plus1_drop", drop_count, 2);
      check("fit_plus1_pkt_count", pkt_count, 0);

      // Random lengths, gaps and sink backpressure; room is reserved so nothing drops
      rand_rdy = 1'b1;
      for (int p = 0; p < 100; p++) begin
         len = $urandom_range(1, 12);
         n = 0;
         while (exp_q.size() + len > DEPTH && n < 2000) begin
            tick();
            n++;
         end
         if (n >= 2000) check("rand_room", exp_q.size() + len, DEPTH);
         send_pkt(len, 1'b1, 30);
      end
      wait_drain("rand_drain");
      rand_rdy = 1'b0;
      tick();
      m_TREADY = 1'b1;
      check("rand_no_drop", drop_count, 2);

      // Full rate with the sink always ready
      send_pkt(12, 1'b1, 0);
      tick();
      h0 = n_hs;
      repeat (13) tick();
      check("tput_b2b", n_hs - h0, 12);
      wait_drain("tput_drain");

      // Reset mid-packet discards a committed packet and a partial one
      m_TREADY = 1'b0;
      send_pkt(2, 1'b0, 0);
      for (int i = 0; i < 3; i++) send_beat(rnd_beat(1'b0));
      rst_n = 1'b0;
      tick();
      check("mid_rst_tready", s_TREADY, 0);
      check("mid_rst_mvalid", m_TVALID, 0);
      check("mid_rst_mdata", m_TDATA, 0);
      check("mid_rst_mkeep", m_TKEEP, 0);
      check("mid_rst_mlast", m_TLAST, 0);
      check("mid_rst_pkt_count", pkt_count, 0);
      check("mid_rst_drop_count", drop_count, 0);
      check("mid_rst_drop_pulse", drop_pulse, 0);
      rst_n = 1'b1;
      tick();
      check("mid_rst_tready_rel", s_TREADY, 1);
      m_TREADY = 1'b1;
      send_pkt(2, 1'b1, 0);
      wait_drain("post_rst_drain");
      check("post_rst_pkt_count", pkt_count, 0);
      check("post_rst_drop_count", drop_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
